dm_access_arbiter: RTL and testbench
====================================

Name: dm_access_arbiter

Overview:
- Shares the byte-wide data memory (64 x 8 by default) between two requesters: port 0 = core load/store path, port 1 = loader/debug port.
- Sequences byte/half/word loads and stores into one memory byte per cycle, little-endian.
- Applies sign/zero extension on loads using the DMCtrl encoding.
- Round-robin arbitration; one transaction in flight at a time.

Parameters:
- ADDR_W, 6, memory byte-address width (depth = 2^ADDR_W bytes).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  port 0 request; held high until ack0.
- addr0  input  32  port 0 byte address.
- wdata0  input  32  port 0 store data.
- wr0  input  1  port 0: 1 = store, 0 = load.
- ctrl0  input  3  port 0 size/sign (DMCtrl encoding).
- req1, addr1, wdata1, wr1, ctrl1  input  1/32/32/1/3  port 1, same meaning as port 0.
- ack0  output  1  one-cycle completion pulse for port 0.
- ack1  output  1  one-cycle completion pulse for port 1.
- rdata  output  32  load result; valid only in the ack cycle.
- err  output  1  error flag; valid only in the ack cycle.
- busy  output  1  high in XFER and RESP.
- memAddr  output  ADDR_W  byte address to memory.
- memWrData  output  8  byte to write.
- memWrEn  output  1  byte write strobe; memory writes on the clk edge.
- memRdData  input  8  combinational read of mem[memAddr].

Behaviour:
- Reset: all outputs 0; FSM = IDLE; lastGrant = 1, so port 0 wins the first tie.
- ctrl encoding:
  - 000 = byte, signed.
  - 001 = half, signed.
  - 010 = word.
  - 100 = byte, unsigned.
  - 101 = half, unsigned.
  - Stores use size only (000/100 = 1 byte, 001/101 = 2 bytes, 010 = 4 bytes).
  - 011, 110, 111 are illegal.
- IDLE:
  - If any req is high, grant one: if only one is high, grant it; if both are high, grant the port != lastGrant.
  - Latch addr, wdata, wr, ctrl and compute N = 1/2/4 bytes. Update lastGrant. Go to XFER with idx = 0.
  - Illegal ctrl: skip XFER, go straight to RESP with err = 1. No memory access.
- XFER, one cycle per byte, idx = 0..N-1:
  - memAddr = (addr + idx) mod 2^ADDR_W. Wrap-around is legal and not an error.
  - Store: memWrEn = 1, memWrData = wdata[8*idx+7 : 8*idx].
  - Load: memWrEn = 0; capture memRdData into byte lane idx.
  - After idx = N-1, go to RESP.
- RESP (one cycle):
  - Pulse ack of the granted port.
  - Load: rdata = extended result. Signed uses bit 7 (byte) or bit 15 (half) of the assembled value; unsigned zero-fills.
  - Store: rdata = 0. Go to IDLE.
- Latency: request sampled in IDLE at cycle T; ack at T+1+N. Word = 6 cycles, byte = 3 cycles, illegal ctrl = 2 cycles (ack at T+1).
- Back-to-back: at least one IDLE cycle between transactions; a requester holding req is re-eligible in that IDLE.
- Request fields are sampled only at grant. Changing inputs or dropping req mid-transfer does not alter the transaction; ack still pulses.
- memWrEn, memAddr and memWrData are 0 outside XFER.
- rst mid-transfer:
  - Next cycle returns to IDLE with all outputs 0 and no ack.
  - Bytes already written stay written; the remaining bytes are not written.
- Only ADDR_W LSBs of addr are used; upper bits are ignored.

Optional Feature:
- Macro: DM_ALIGN_CHECK_EN.
- Defined:
  - Half with addr[0] != 0, or word with addr[1:0] != 0, is misaligned.
  - Misaligned requests go IDLE -> RESP with err = 1, rdata = 0, no memory access (ack at T+1).
- Undefined:
  - Misaligned accesses proceed byte by byte as normal.
  - err is raised only for illegal ctrl.

Test Plan:
- Word store then load:
  - Port 0 stores 0x8765_4321 to addr 0x10 (wr0 = 1, ctrl0 = 010).
  - Required: mem[0x10..0x13] = 21, 43, 65, 87; ack0 at T+5.
  - Then load ctrl0 = 010 from 0x10 -> rdata = 0x8765_4321 at ack.
- Sign/zero extension:
  - mem[0x20] = 0xF0. Port 1 loads ctrl1 = 000 -> rdata = 0xFFFF_FFF0; ctrl1 = 100 -> rdata = 0x0000_00F0.
  - Half at 0x20 with mem[0x21] = 0x80, ctrl1 = 001 -> rdata = 0xFFFF_80F0.
- Arbitration:
  - req0 and req1 both held high from reset for 3 transactions.
  - Required grant order 0, 1, 0; never two acks in the same cycle.
- Wrap:
  - Word store 0xAABB_CCDD at addr 0x3E.
  - Required: mem[0x3E] = DD, mem[0x3F] = CC, mem[0x00] = BB, mem[0x01] = AA; err = 0.
- Reset mid-op:
  - rst asserted in the 2nd XFER cycle of a word store.
  - Required: only 1 byte written; no ack; all outputs 0 the next cycle.
- Errors:
  - ctrl0 = 111 -> ack0 and err = 1 at T+1, memWrEn never high.
  - With DM_ALIGN_CHECK_EN defined: word load at 0x02 -> err = 1, rdata = 0, ack at T+1.

Source files
------------

// File: rtl/dm_access_arbiter.sv
// dm_access_arbiter
// Shares a byte-wide data memory between the core load/store path (port 0)
// and the loader/debug port (port 1). Word, half and byte accesses are
// sequenced one memory byte per cycle, little-endian, with round-robin
// arbitration and a single transaction in flight.
// Optional build macro: DM_ALIGN_CHECK_EN rejects misaligned half/word
// accesses with err instead of performing them byte by byte.
module dm_access_arbiter #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [31:0]       addr0,
  input  logic [31:0]       wdata0,
  input  logic              wr0,
  input  logic [2:0]        ctrl0,
  input  logic              req1,
  input  logic [31:0]       addr1,
  input  logic [31:0]       wdata1,
  input  logic              wr1,
  input  logic [2:0]        ctrl1,
  output logic              ack0,
  output logic              ack1,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] memAddr,
  output logic [7:0]        memWrData,
  output logic              memWrEn,
  input  logic [7:0]        memRdData
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            nextState;

  logic              lastGrant;
  logic              grantPort;
  logic [ADDR_W-1:0] addrQ;
  logic [31:0]       wdataQ;
  logic              wrQ;
  logic [2:0]        ctrlQ;
  logic [1:0]        idx;
  logic [1:0]        lastIdx;
  logic [31:0]       rdBuf;
  logic              errQ;

  logic              anyReq;
  logic              selPort;
  logic [ADDR_W-1:0] selAddr;
  logic [31:0]       selWdata;
  logic              selWr;
  logic [2:0]        selCtrl;
  logic [1:0]        selLastIdx;
  logic              selIllegal;
  logic              selMisaligned;
  logic              selReject;
  logic [31:0]       loadValue;

  // Address bits above the memory width are intentionally ignored.
  logic              unusedAddrBits;
  assign unusedAddrBits = ^{addr0[31:ADDR_W], addr1[31:ADDR_W]};

  // Round-robin pick: a lone requester wins, a tie goes to the port that was not granted last.
  always_comb begin
    anyReq  = req0 | req1;
    selPort = 1'b0;
    if (req0 && req1) begin
      selPort = ~lastGrant;
    end else if (req1) begin
      selPort = 1'b1;
    end
    selAddr  = selPort ? addr1[ADDR_W-1:0] : addr0[ADDR_W-1:0];
    selWdata = selPort ? wdata1 : wdata0;
    selWr    = selPort ? wr1 : wr0;
    selCtrl  = selPort ? ctrl1 : ctrl0;
  end

  // Decode the size of the selected request and whether it must be rejected without touching memory.
  always_comb begin
    selIllegal = (selCtrl == 3'b011) || (selCtrl[2:1] == 2'b11);
    case (selCtrl[1:0])
      2'b00:   selLastIdx = 2'd0;
      2'b01:   selLastIdx = 2'd1;
      default: selLastIdx = 2'd3;
    endcase
`ifdef DM_ALIGN_CHECK_EN
    selMisaligned = ((selCtrl[1:0] == 2'b01) && selAddr[0]) ||
                    ((selCtrl[1:0] == 2'b10) && (selAddr[1:0] != 2'b00));
`else
    selMisaligned = 1'b0;
`endif
    selReject = selIllegal | selMisaligned;
  end

  // Next-state logic: rejected requests bypass XFER and answer immediately.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (anyReq) begin
          nextState = selReject ? RESP : XFER;
        end
      end
      XFER: begin
        if (idx == lastIdx) begin
          nextState = RESP;
        end
      end
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Latch the granted request and assemble load bytes one lane per XFER cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      lastGrant <= 1'b1;
      grantPort <= 1'b0;
      addrQ     <= '0;
      wdataQ    <= '0;
      wrQ       <= 1'b0;
      ctrlQ     <= '0;
      lastIdx   <= '0;
      idx       <= '0;
      rdBuf     <= '0;
      errQ      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (anyReq) begin
            lastGrant <= selPort;
            grantPort <= selPort;
            addrQ     <= selAddr;
            wdataQ    <= selWdata;
            wrQ       <= selWr;
            ctrlQ     <= selCtrl;
            lastIdx   <= selLastIdx;
            idx       <= 2'd0;
            rdBuf     <= '0;
            errQ      <= selReject;
          end
        end
        XFER: begin
          if (!wrQ) begin
            rdBuf[{idx, 3'b000} +: 8] <= memRdData;
          end
          idx <= idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Sign or zero extend the assembled load according to the latched size/sign code.
  always_comb begin
    case (ctrlQ)
      3'b000:  loadValue = {{24{rdBuf[7]}}, rdBuf[7:0]};
      3'b001:  loadValue = {{16{rdBuf[15]}}, rdBuf[15:0]};
      3'b100:  loadValue = {24'h000000, rdBuf[7:0]};
      3'b101:  loadValue = {16'h0000, rdBuf[15:0]};
      default: loadValue = rdBuf;
    endcase
  end

  // Drive memory and response outputs; memWrEn is cut by rst so a reset mid-store stops the pending byte.
  always_comb begin
    ack0      = 1'b0;
    ack1      = 1'b0;
    rdata     = '0;
    err       = 1'b0;
    memAddr   = '0;
    memWrData = '0;
    memWrEn   = 1'b0;
    busy      = (state != IDLE);
    case (state)
      XFER: begin
        memAddr = addrQ + ADDR_W'(idx);
        if (wrQ) begin
          memWrEn   = ~rst;
          memWrData = wdataQ[{idx, 3'b000} +: 8];
        end
      end
      RESP: begin
        ack0  = ~grantPort;
        ack1  = grantPort;
        err   = errQ;
        rdata = (wrQ || errQ) ? 32'h0 : loadValue;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dm_access_arbiter.sv
// tb_dm_access_arbiter
// Self-checking bench for dm_access_arbiter with a 64-byte memory model.
// Expected responses are queued when a request is driven and popped on ack.
// Latency is counted in falling edges from the cycle the request is first
// presented in IDLE up to and including the ack cycle.
module tb_dm_access_arbiter;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              req0;
  logic [31:0]       addr0;
  logic [31:0]       wdata0;
  logic              wr0;
  logic [2:0]        ctrl0;
  logic              req1;
  logic [31:0]       addr1;
  logic [31:0]       wdata1;
  logic              wr1;
  logic [2:0]        ctrl1;
  logic              ack0;
  logic              ack1;
  logic [31:0]       rdata;
  logic              err;
  logic              busy;
  logic [ADDR_W-1:0] memAddr;
  logic [7:0]        memWrData;
  logic              memWrEn;
  logic [7:0]        memRdData;

  logic [7:0]        mem [DEPTH];
  exp_t              expQ[$];
  int                checks = 0;
  int                passes = 0;

  dm_access_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .wr0(wr0), .ctrl0(ctrl0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .wr1(wr1), .ctrl1(ctrl1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy),
    .memAddr(memAddr), .memWrData(memWrData), .memWrEn(memWrEn),
    .memRdData(memRdData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory: combinational read, write on the rising edge.
  assign memRdData = mem[memAddr];
  always @(posedge clk) begin
    if (memWrEn) mem[memAddr] <= memWrData;
  end

  function automatic exp_t mkExp(int p, logic [31:0] r, logic e, int l);
    exp_t x;
    x.port  = p;
    x.rdata = r;
    x.err   = e;
    x.lat   = l;
    return x;
  endfunction

  task automatic applyStimulus(input int port, input logic [31:0] a, input logic [31:0] d,
                               input logic w, input logic [2:0] c);
    if (port == 0) begin
      addr0 = a; wdata0 = d; wr0 = w; ctrl0 = c; req0 = 1'b1;
    end else begin
      addr1 = a; wdata1 = d; wr1 = w; ctrl1 = c; req1 = 1'b1;
    end
  endtask

  // Samples on falling edges until an ack appears or the budget runs out.
  task automatic waitAck(input int maxCyc, output logic got, output int p, output logic [31:0] rd,
                         output logic e, output int cyc, output logic sawWr, output logic dbl);
    got = 1'b0; p = -1; rd = '0; e = 1'b0; cyc = 0; sawWr = 1'b0; dbl = 1'b0;
    while (!got && cyc < maxCyc) begin
      @(negedge clk);
      cyc++;
      if (memWrEn) sawWr = 1'b1;
      if (ack0 || ack1) begin
        got = 1'b1;
        p   = ack1 ? 1 : 0;
        rd  = rdata;
        e   = err;
        dbl = ack0 & ack1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0 = 1'b0; addr0 = '0; wdata0 = '0; wr0 = 1'b0; ctrl0 = '0;
    req1 = 1'b0; addr1 = '0; wdata1 = '0; wr1 = 1'b0; ctrl1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ack0, ack1, rdata, err, busy, memAddr, memWrData, memWrEn} !== 51'd0)
      $display("[TB] FAIL reset_hold: outputs=%h expected 0",
               {ack0, ack1, rdata, err, busy, memAddr, memWrData, memWrEn});
    else passes++;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, ack0, ack1, memWrEn} !== 4'b0000)
      $display("[TB] FAIL reset_release: busy/ack0/ack1/memWrEn=%b expected 0000", {busy, ack0, ack1, memWrEn});
    else passes++;
  endtask

  task automatic test_arbitration();
    logic got, e, sawWr, dbl;
    int p, cyc;
    logic [31:0] rd;
    exp_t ex;
    @(posedge clk); #1;
    applyStimulus(0, 32'h30, 32'h0000_00A0, 1'b1, 3'b000);
    applyStimulus(1, 32'h31, 32'h0000_00B1, 1'b1, 3'b000);
    expQ.push_back(mkExp(0, 32'h0, 1'b0, 0));
    expQ.push_back(mkExp(1, 32'h0, 1'b0, 0));
    expQ.push_back(mkExp(0, 32'h0, 1'b0, 0));
    for (int i = 0; i < 3; i++) begin
      waitAck(10, got, p, rd, e, cyc, sawWr, dbl);
      ex = expQ.pop_front();
      checks++;
      if (!got) $display("[TB] FAIL arb_ack%0d: no ack within 10 cycles, expected ack on port %0d", i, ex.port);
      else if (p !== ex.port || dbl !== 1'b0 || e !== ex.err)
        $display("[TB] FAIL arb_grant%0d: port=%0d both=%b err=%b expected port=%0d both=0 err=%b",
                 i, p, dbl, e, ex.port, ex.err);
      else passes++;
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if ({mem[6'h31], mem[6'h30]} !== 16'hB1A0)
      $display("[TB] FAIL arb_mem: mem[31:30]=%h expected b1a0", {mem[6'h31], mem[6'h30]});
    else passes++;
  endtask

  task automatic test_word_store_load();
    logic got, e, sawWr, dbl;
    int p, cyc;
    logic [31:0] rd;
    exp_t ex;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      applyStimulus(0, 32'h10, 32'h8765_4321, (i == 0), 3'b010);
      expQ.push_back(mkExp(0, (i == 0) ? 32'h0 : 32'h8765_4321, 1'b0, 6));
      waitAck(20, got, p, rd, e, cyc, sawWr, dbl);
      req0 = 1'b0;
      ex = expQ.pop_front();
      checks++;
      if (!got) $display("[TB] FAIL word_txn%0d: no ack within 20 cycles", i);
      else if (p !== ex.port || rd !== ex.rdata || e !== ex.err || cyc !== ex.lat)
        $display("[TB] FAIL word_txn%0d: port=%0d rdata=%h err=%b lat=%0d expected port=%0d rdata=%h err=%b lat=%0d",
                 i, p, rd, e, cyc, ex.port, ex.rdata, ex.err, ex.lat);
      else passes++;
      if (i == 0) begin
        checks++;
        if ({mem[6'h13], mem[6'h12], mem[6'h11], mem[6'h10]} !== 32'h8765_4321)
          $display("[TB] FAIL word_mem: mem[13:10]=%h expected 87654321",
                   {mem[6'h13], mem[6'h12], mem[6'h11], mem[6'h10]});
        else passes++;
      end
    end
  endtask

  task automatic test_sign_ext();
    logic got, e, sawWr, dbl;
    int p, cyc;
    logic [31:0] rd;
    exp_t ex;
    logic [31:0] tAddr [6] = '{32'h20, 32'h21, 32'h20, 32'h20, 32'h20, 32'h20};
    logic [31:0] tData [6] = '{32'hF0, 32'h80, 32'h0, 32'h0, 32'h0, 32'h0};
    logic        tWr   [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [2:0]  tCtrl [6] = '{3'b000, 3'b100, 3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] tExp  [6] = '{32'h0, 32'h0, 32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_80F0, 32'h0000_80F0};
    int          tLat  [6] = '{3, 3, 3, 3, 4, 4};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      applyStimulus(1, tAddr[i], tData[i], tWr[i], tCtrl[i]);
      expQ.push_back(mkExp(1, tExp[i], 1'b0, tLat[i]));
      waitAck(20, got, p, rd, e, cyc, sawWr, dbl);
      req1 = 1'b0;
      ex = expQ.pop_front();
      checks++;
      if (!got) $display("[TB] FAIL ext_txn%0d: no ack within 20 cycles", i);
      else if (p !== ex.port || rd !== ex.rdata || e !== ex.err || cyc !== ex.lat)
        $display("[TB] FAIL ext_txn%0d: port=%0d rdata=%h err=%b lat=%0d expected port=%0d rdata=%h err=%b lat=%0d",
                 i, p, rd, e, cyc, ex.port, ex.rdata, ex.err, ex.lat);
      else passes++;
    end
  endtask

  task automatic test_wrap();
    logic got, e, sawWr, dbl;
    int p, cyc;
    logic [31:0] rd;
    exp_t ex;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      applyStimulus(0, 32'hFFFF_FF3E, 32'hAABB_CCDD, (i == 0), 3'b010);
      expQ.push_back(mkExp(0, (i == 0) ? 32'h0 : 32'hAABB_CCDD, 1'b0, 6));
      waitAck(20, got, p, rd, e, cyc, sawWr, dbl);
      req0 = 1'b0;
      ex = expQ.pop_front();
      checks++;
      if (!got) $display("[TB] FAIL wrap_txn%0d: no ack within 20 cycles", i);
      else if (p !== ex.port || rd !== ex.rdata || e !== ex.err || cyc !== ex.lat)
        $display("[TB] FAIL wrap_txn%0d: port=%0d rdata=%h err=%b lat=%0d expected port=%0d rdata=%h err=%b lat=%0d",
                 i, p, rd, e, cyc, ex.port, ex.rdata, ex.err, ex.lat);
      else passes++;
      if (i == 0) begin
        checks++;
        if ({mem[6'h01], mem[6'h00], mem[6'h3F], mem[6'h3E]} !== 32'hAABB_CCDD)
          $display("[TB] FAIL wrap_mem: mem[01,00,3f,3e]=%h expected aabbccdd",
                   {mem[6'h01], mem[6'h00], mem[6'h3F], mem[6'h3E]});
        else passes++;
      end
    end
  endtask

  task automatic test_errors();
    logic got, e, sawWr, dbl;
    int p, cyc;
    logic [31:0] rd;
    exp_t ex;
    logic [2:0]  tCtrl [5] = '{3'b111, 3'b011, 3'b110, 3'b010, 3'b010};
    logic        tWr   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] tAddr [5] = '{32'h04, 32'h04, 32'h04, 32'h02, 32'h02};
    logic [31:0] tData [5] = '{32'hDEAD_BEEF, 32'h0, 32'h1234_5678, 32'h0BAD_F00D, 32'h0};
    logic [31:0] tExp  [5];
    logic        tErr  [5];
    int          tLat  [5];
    for (int i = 0; i < 3; i++) begin
      tExp[i] = 32'h0; tErr[i] = 1'b1; tLat[i] = 2;
    end
`ifdef DM_ALIGN_CHECK_EN
    tExp[3] = 32'h0; tErr[3] = 1'b1; tLat[3] = 2;
    tExp[4] = 32'h0; tErr[4] = 1'b1; tLat[4] = 2;
`else
    tExp[3] = 32'h0;         tErr[3] = 1'b0; tLat[3] = 6;
    tExp[4] = 32'h0BAD_F00D; tErr[4] = 1'b0; tLat[4] = 6;
`endif
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      applyStimulus(0, tAddr[i], tData[i], tWr[i], tCtrl[i]);
      expQ.push_back(mkExp(0, tExp[i], tErr[i], tLat[i]));
      waitAck(20, got, p, rd, e, cyc, sawWr, dbl);
      req0 = 1'b0;
      ex = expQ.pop_front();
      checks++;
      if (!got) $display("[TB] FAIL err_txn%0d: no ack within 20 cycles", i);
      else if (p !== ex.port || rd !== ex.rdata || e !== ex.err || cyc !== ex.lat ||
               (ex.err && sawWr))
        $display("[TB] FAIL err_txn%0d: port=%0d rdata=%h err=%b lat=%0d wrote=%b expected port=%0d rdata=%h err=%b lat=%0d wrote=0",
                 i, p, rd, e, cyc, sawWr, ex.port, ex.rdata, ex.err, ex.lat);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    logic got, e, sawWr, dbl;
    int p, cyc;
    logic [31:0] rd;
    exp_t ex;
    @(posedge clk); #1;
    applyStimulus(1, 32'h20, 32'h0, 1'b0, 3'b100);
    @(posedge clk); #1;
    addr1 = 32'h21;
    expQ.push_back(mkExp(1, 32'h0000_00F0, 1'b0, 2));
    expQ.push_back(mkExp(1, 32'h0000_0080, 1'b0, 3));
    for (int i = 0; i < 2; i++) begin
      waitAck(10, got, p, rd, e, cyc, sawWr, dbl);
      ex = expQ.pop_front();
      checks++;
      if (!got) $display("[TB] FAIL b2b_txn%0d: no ack within 10 cycles", i);
      else if (p !== ex.port || rd !== ex.rdata || e !== ex.err || cyc !== ex.lat)
        $display("[TB] FAIL b2b_txn%0d: port=%0d rdata=%h err=%b lat=%0d expected port=%0d rdata=%h err=%b lat=%0d",
                 i, p, rd, e, cyc, ex.port, ex.rdata, ex.err, ex.lat);
      else passes++;
    end
    req1 = 1'b0;
  endtask

  task automatic test_reset_midop();
    logic got, e, sawWr, dbl;
    int p, cyc;
    logic [31:0] rd;
    logic sawAck;
    exp_t ex;
    @(posedge clk); #1;
    applyStimulus(0, 32'h08, 32'hEEEE_EEEE, 1'b1, 3'b010);
    expQ.push_back(mkExp(0, 32'h0, 1'b0, 6));
    waitAck(20, got, p, rd, e, cyc, sawWr, dbl);
    req0 = 1'b0;
    ex = expQ.pop_front();
    checks++;
    if (!got || p !== ex.port || e !== ex.err || cyc !== ex.lat)
      $display("[TB] FAIL midop_prefill: got=%b port=%0d err=%b lat=%0d expected got=1 port=%0d err=%b lat=%0d",
               got, p, e, cyc, ex.port, ex.err, ex.lat);
    else passes++;
    @(posedge clk); #1;
    applyStimulus(0, 32'h08, 32'h1122_3344, 1'b1, 3'b010);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1; req0 = 1'b0;
    sawAck = 1'b0;
    @(negedge clk);
    if (ack0 || ack1) sawAck = 1'b1;
    checks++;
    if (memWrEn !== 1'b0) $display("[TB] FAIL midop_wr_gate: memWrEn=%b expected 0 while rst high", memWrEn);
    else passes++;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ack0, ack1, rdata, err, busy, memAddr, memWrData, memWrEn} !== 51'd0)
      $display("[TB] FAIL midop_outputs: outputs=%h expected 0",
               {ack0, ack1, rdata, err, busy, memAddr, memWrData, memWrEn});
    else passes++;
    repeat (4) begin
      @(negedge clk);
      if (ack0 || ack1) sawAck = 1'b1;
    end
    checks++;
    if (sawAck !== 1'b0) $display("[TB] FAIL midop_no_ack: ack seen=%b expected 0", sawAck);
    else passes++;
    checks++;
    if ({mem[6'h0B], mem[6'h0A], mem[6'h09], mem[6'h08]} !== 32'hEEEE_EE44)
      $display("[TB] FAIL midop_mem: mem[0b:08]=%h expected eeeeee44",
               {mem[6'h0B], mem[6'h0A], mem[6'h09], mem[6'h08]});
    else passes++;
  endtask

  // Guards against a hung handshake that no bounded wait caught.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at 200000 ns, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] dm_access_arbiter bench start");
    test_reset();
    test_arbitration();
    test_word_store_load();
    test_sign_ext();
    test_wrap();
    test_errors();
    test_back_to_back();
    test_reset_midop();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
